// File: rtl/regfile_pkg.sv
// Shared types and defaults for the scoreboarded register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    S_INIT,
    S_RUN
  } state_e;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned NUM_RD_DEF = 3;
  localparam int unsigned DEPTH_DEF  = 2 ** ADDR_W_DEF;
  localparam int unsigned ZERO_ADDR  = 0;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/writeback/preload bus of the scoreboarded register file.
interface regfile_scoreboard_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NUM_RD = NUM_RD_DEF
) ();

  logic                     init_we;
  logic [ADDR_W-1:0]        init_addr;
  logic [DATA_W-1:0]        init_data;
  logic                     init_done;
  logic                     ready;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     rsv_en;
  logic [ADDR_W-1:0]        rsv_addr;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     flush;
  logic                     err_unrsv;

  modport master (
    output init_we, init_addr, init_data, init_done, rd_addr,
    output rsv_en, rsv_addr, wr_en, wr_addr, wr_data, flush,
    input  ready, rd_data, rd_busy, err_unrsv
  );

  modport slave (
    input  init_we, init_addr, init_data, init_done, rd_addr,
    input  rsv_en, rsv_addr, wr_en, wr_addr, wr_data, flush,
    output ready, rd_data, rd_busy, err_unrsv
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read port: address mux, zero-register forcing, optional
// same-cycle write bypass (enabled by REGFILE_BYPASS_EN).
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned ZERO_REG = 1,
  localparam int unsigned DEPTH   = 2 ** ADDR_W
) (
  input  logic [DEPTH-1:0][DATA_W-1:0] regs_i,
  input  logic [DEPTH-1:0]             busy_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic                         byp_en_i,
  input  logic [ADDR_W-1:0]            byp_addr_i,
  input  logic [DATA_W-1:0]            byp_data_i,
  input  logic                         rsv_en_i,
  input  logic [ADDR_W-1:0]            rsv_addr_i,
  output logic [DATA_W-1:0]            data_o,
  output logic                         busy_o
);

  always_comb begin
    data_o = regs_i[addr_i];
    busy_o = busy_i[addr_i];
`ifdef REGFILE_BYPASS_EN
    // Writeback clears busy this edge; only a same-cycle reserve keeps it set.
    if (byp_en_i && (addr_i == byp_addr_i)) begin
      data_o = byp_data_i;
      busy_o = rsv_en_i && (rsv_addr_i == addr_i);
    end
`endif
    if ((ZERO_REG != 0) && (addr_i == ADDR_W'(ZERO_ADDR))) begin
      data_o = '0;
      busy_o = 1'b0;
    end
  end

`ifndef REGFILE_BYPASS_EN
  logic unused_byp;
  assign unused_byp = ^{byp_en_i, byp_addr_i, byp_data_i, rsv_en_i, rsv_addr_i};
`endif

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with serial preload and per-register busy scoreboard.
// Optional same-cycle write bypass on reads: define REGFILE_BYPASS_EN.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = NUM_RD_DEF,
  parameter int unsigned ZERO_REG = 1
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  regfile_scoreboard_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  state_e                         state_q, state_d;
  logic [DEPTH-1:0][DATA_W-1:0]   regs_q, regs_d;
  logic [DEPTH-1:0]               busy_q, busy_d;
  logic                           err_q, err_d;

  logic run, wr_zero, rsv_zero, init_zero;

  assign run       = (state_q == S_RUN);
  assign wr_zero   = (ZERO_REG != 0) && (bus.wr_addr == ADDR_W'(ZERO_ADDR));
  assign rsv_zero  = (ZERO_REG != 0) && (bus.rsv_addr == ADDR_W'(ZERO_ADDR));
  assign init_zero = (ZERO_REG != 0) && (bus.init_addr == ADDR_W'(ZERO_ADDR));

  always_comb begin
    state_d = state_q;
    regs_d  = regs_q;
    busy_d  = busy_q;
    err_d   = err_q;
    unique case (state_q)
      S_INIT: begin
        if (bus.init_we && !init_zero) begin
          regs_d[bus.init_addr] = bus.init_data;
        end
        if (bus.init_done) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.wr_en && !wr_zero) begin
          regs_d[bus.wr_addr] = bus.wr_data;
          busy_d[bus.wr_addr] = 1'b0;
          if (!busy_q[bus.wr_addr]) begin
            err_d = 1'b1;
          end
        end
        // Reserve after clear so a same-address reserve wins; flush beats both.
        if (bus.rsv_en && !rsv_zero) begin
          busy_d[bus.rsv_addr] = 1'b1;
        end
        if (bus.flush) begin
          busy_d = '0;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_INIT;
      regs_q  <= '0;
      busy_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      regs_q  <= regs_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign bus.ready     = run;
  assign bus.err_unrsv = err_q;

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    regfile_read_port #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .ZERO_REG(ZERO_REG)
    ) u_rd (
      .regs_i    (regs_q),
      .busy_i    (busy_q),
      .addr_i    (bus.rd_addr[g*ADDR_W +: ADDR_W]),
      .byp_en_i  (run && bus.wr_en),
      .byp_addr_i(bus.wr_addr),
      .byp_data_i(bus.wr_data),
      .rsv_en_i  (run && bus.rsv_en && !bus.flush),
      .rsv_addr_i(bus.rsv_addr),
      .data_o    (bus.rd_data[g*DATA_W +: DATA_W]),
      .busy_o    (bus.rd_busy[g])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed and random checks of regfile_scoreboard against an array-based reference model.
module tb_regfile_scoreboard;
  import regfile_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned NR = 3;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned ZR = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  regfile_scoreboard #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .NUM_RD  (NR),
    .ZERO_REG(ZR)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] m_reg [DEPTH];
  bit            m_busy[DEPTH];
  bit            m_err;
  bit            m_run;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_zero(input int a);
    return (ZR != 0) && (a == 0);
  endfunction

  function automatic logic [DW-1:0] rd(input int p);
    return bus.rd_data[p*DW +: DW];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
    m_run = 1'b0;
  endtask

  // Applies the inputs present at the rising edge to the model.
  task automatic model_clock();
    int wa, ra, ia;
    wa = int'(bus.wr_addr);
    ra = int'(bus.rsv_addr);
    ia = int'(bus.init_addr);
    if (!m_run) begin
      if (bus.init_we && !is_zero(ia)) m_reg[ia] = bus.init_data;
      if (bus.init_done) m_run = 1'b1;
    end else begin
      if (bus.wr_en && !is_zero(wa)) begin
        if (!m_busy[wa]) m_err = 1'b1;
        m_reg[wa]  = bus.wr_data;
        m_busy[wa] = 1'b0;
      end
      if (bus.rsv_en && !is_zero(ra)) m_busy[ra] = 1'b1;
      if (bus.flush) begin
        for (int i = 0; i < DEPTH; i++) m_busy[i] = 1'b0;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    int a;
    logic [DW-1:0] ed;
    bit eb;
    for (int p = 0; p < NR; p++) begin
      a  = int'(bus.rd_addr[p*AW +: AW]);
      ed = m_reg[a];
      eb = m_busy[a];
`ifdef REGFILE_BYPASS_EN
      if (m_run && bus.wr_en && (a == int'(bus.wr_addr))) begin
        ed = bus.wr_data;
        eb = bus.rsv_en && !bus.flush && (int'(bus.rsv_addr) == a);
      end
`endif
      if (is_zero(a)) begin
        ed = '0;
        eb = 1'b0;
      end
      check($sformatf("%s_data%0d", tag, p), rd(p), ed);
      check($sformatf("%s_busy%0d", tag, p), DW'(bus.rd_busy[p]), DW'(eb));
    end
    check({tag, "_ready"}, DW'(bus.ready), DW'(m_run));
    check({tag, "_err"}, DW'(bus.err_unrsv), DW'(m_err));
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    bus.init_we   = 1'b0;
    bus.init_addr = '0;
    bus.init_data = '0;
    bus.init_done = 1'b0;
    bus.rsv_en    = 1'b0;
    bus.rsv_addr  = '0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1, input int a2);
    bus.rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    idle();
    set_rd(12, 13, 15);
    model_reset();
    #2;
    check_outputs("por");
    check("por_ready", DW'(bus.ready), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Preload 12..15, then leave S_INIT.
    for (int k = 0; k < 4; k++) begin
      bus.init_we   = 1'b1;
      bus.init_addr = AW'(12 + k);
      bus.init_data = DW'(11 * (k + 1));
      cycle("pre");
    end
    idle();
    bus.init_done = 1'b1;
    cycle("pre_done");
    idle();
    #1;
    check("pre_ready", DW'(bus.ready), DW'(1));
    check("pre_p0", rd(0), DW'(11));
    check("pre_p1", rd(1), DW'(22));
    check("pre_p2", rd(2), DW'(44));
    cycle("pre_rd");

    // Reserve then write register 2.
    set_rd(2, 2, 0);
    bus.rsv_en = 1'b1; bus.rsv_addr = AW'(2);
    cycle("rsv2");
    idle();
    #1 check("rsv2_busy", DW'(bus.rd_busy[0]), DW'(1));
    bus.wr_en = 1'b1; bus.wr_addr = AW'(2); bus.wr_data = DW'(789);
    cycle("wr2");
    idle();
    #1;
    check("wr2_data", rd(0), DW'(789));
    check("wr2_busy", DW'(bus.rd_busy[0]), DW'(0));
    cycle("wr2_after");

    // Same-edge reserve and write to 4, then flush with a reserve of 5.
    bus.rsv_en = 1'b1; bus.rsv_addr = AW'(4);
    cycle("rsv4");
    bus.wr_en = 1'b1; bus.wr_addr = AW'(4); bus.wr_data = DW'(123);
    cycle("coll4");
    idle();
    set_rd(4, 4, 5);
    #1;
    check("coll4_data", rd(0), DW'(123));
    check("coll4_busy", DW'(bus.rd_busy[0]), DW'(1));
    bus.flush = 1'b1; bus.rsv_en = 1'b1; bus.rsv_addr = AW'(5);
    cycle("flush");
    idle();
    #1;
    check("flush_busy4", DW'(bus.rd_busy[0]), DW'(0));
    check("flush_busy5", DW'(bus.rd_busy[2]), DW'(0));
    check("flush_err", DW'(bus.err_unrsv), DW'(0));
    cycle("flush_after");

    // Zero register drops writes and reserves; unreserved write sets err.
    set_rd(0, 6, 0);
    bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = DW'(555);
    cycle("wr0");
    idle();
    bus.rsv_en = 1'b1; bus.rsv_addr = '0;
    cycle("rsv0");
    idle();
    #1;
    check("zero_data", rd(0), DW'(0));
    check("zero_busy", DW'(bus.rd_busy[0]), DW'(0));
    check("zero_err", DW'(bus.err_unrsv), DW'(0));
    bus.wr_en = 1'b1; bus.wr_addr = AW'(6); bus.wr_data = DW'(456);
    cycle("wr6");
    idle();
    #1;
    check("wr6_data", rd(1), DW'(456));
    check("wr6_err", DW'(bus.err_unrsv), DW'(1));
    cycle("err_hold0");
    cycle("err_hold1");

    // Phase gating.
    do_reset();
    set_rd(7, 0, 3);
    bus.wr_en = 1'b1; bus.wr_addr = AW'(7); bus.wr_data = DW'(99);
    bus.rsv_en = 1'b1; bus.rsv_addr = AW'(7); bus.flush = 1'b1;
    bus.init_we = 1'b1; bus.init_addr = '0; bus.init_data = DW'(5);
    cycle("init_gate");
    idle();
    #1;
    check("gate_data7", rd(0), DW'(0));
    check("gate_busy7", DW'(bus.rd_busy[0]), DW'(0));
    check("gate_data0", rd(1), DW'(0));
    bus.init_we = 1'b1; bus.init_addr = AW'(3); bus.init_data = DW'(77); bus.init_done = 1'b1;
    cycle("init_done3");
    idle();
    #1;
    check("init3_ready", DW'(bus.ready), DW'(1));
    check("init3_data", rd(2), DW'(77));
    set_rd(8, 3, 3);
    bus.init_we = 1'b1; bus.init_addr = AW'(8); bus.init_data = DW'(55);
    cycle("run_init");
    idle();
    #1 check("run_init_data", rd(0), DW'(0));

    // Asynchronous reset between edges.
    bus.rsv_en = 1'b1; bus.rsv_addr = AW'(9);
    cycle("pre_rst_rsv");
    idle();
    bus.wr_en = 1'b1; bus.wr_addr = AW'(6); bus.wr_data = DW'(31);
    cycle("pre_rst_wr");
    idle();
    set_rd(9, 6, 3);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_ready", DW'(bus.ready), DW'(0));
    check("mid_rst_busy9", DW'(bus.rd_busy[0]), DW'(0));
    check("mid_rst_data3", rd(2), DW'(0));
    check_outputs("mid_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Random preload (with gated run-only strobes), then random run traffic.
    for (int n = 0; n < 20; n++) begin
      bus.init_we   = 1'($urandom_range(0, 1));
      bus.init_addr = AW'($urandom_range(0, DEPTH - 1));
      bus.init_data = DW'($urandom);
      bus.wr_en     = 1'($urandom_range(0, 1));
      bus.wr_addr   = AW'($urandom_range(0, DEPTH - 1));
      bus.wr_data   = DW'($urandom);
      bus.rsv_en    = 1'($urandom_range(0, 1));
      bus.rsv_addr  = AW'($urandom_range(0, DEPTH - 1));
      bus.flush     = 1'($urandom_range(0, 1));
      set_rd($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
             $urandom_range(0, DEPTH - 1));
      cycle("rnd_init");
    end
    idle();
    bus.init_done = 1'b1;
    cycle("rnd_done");
    for (int n = 0; n < 400; n++) begin
      idle();
      bus.init_we   = 1'($urandom_range(0, 1));
      bus.init_addr = AW'($urandom_range(0, DEPTH - 1));
      bus.init_data = DW'($urandom);
      bus.wr_en     = 1'($urandom_range(0, 1));
      bus.wr_addr   = AW'($urandom_range(0, DEPTH - 1));
      bus.wr_data   = DW'($urandom);
      bus.rsv_en    = 1'($urandom_range(0, 1));
      bus.rsv_addr  = AW'($urandom_range(0, DEPTH - 1));
      bus.flush     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) begin
        set_rd(int'(bus.wr_addr), int'(bus.rsv_addr), $urandom_range(0, DEPTH - 1));
      end else begin
        set_rd($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1),
               $urandom_range(0, DEPTH - 1));
      end
      cycle("rnd_run");
    end
    idle();
    cycle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
